sync_fifo_adv: RTL and testbench

SYNC_FIFO_ADV -- requirements
Module: sync_fifo_adv

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_ptr_wrap.sv | 29 ++
 rtl/sync_fifo_adv.sv | 201 ++++++++++++++++++++
 tb/tb_sync_fifo_adv.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO family.
//   fifo_mode_e  : read-side behaviour (registered read or first-word-fall-through)
//   count_width  : width of an occupancy counter able to hold 0..depth inclusive
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy must represent both 0 and depth, hence depth+1 states.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// -----------------------------------------------------------------------------
// fifo_ptr_wrap
// Modulo-DEPTH pointer increment, valid for any DEPTH >= 2 (power of two or not).
// Ports:
//   ptr     in  PTR_W  current pointer value (0..DEPTH-1)
//   adv     in  1      advance request
//   ptr_nxt out PTR_W  ptr+1 wrapped to 0 after DEPTH-1 when adv=1, else ptr
// -----------------------------------------------------------------------------
module fifo_ptr_wrap #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic             adv,
  output logic [PTR_W-1:0] ptr_nxt
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_comb begin
    ptr_nxt = ptr;
    if (adv) begin
      // Explicit compare instead of natural binary rollover so that
      // non-power-of-two depths wrap at the right entry.
      ptr_nxt = (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_adv.sv
// -----------------------------------------------------------------------------
// sync_fifo_adv
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags, peak-occupancy watermark and a
// synchronous flush. Supports a registered-read mode and a first-word-fall-
// through mode, selected by FWFT.
//
// Ports:
//   clk           in   1           rising-edge clock
//   rst_n         in   1           asynchronous active-low reset
//   flush         in   1           synchronous clear of pointers/count/flags
//   wr_en         in   1           write request
//   wr_data       in   DATA_WIDTH  write word
//   full          out  1           count == DEPTH
//   almost_full   out  1           count >= AF_THRESH
//   overflow      out  1           sticky: a write was rejected
//   rd_en         in   1           read request
//   rd_data       out  DATA_WIDTH  read word (registered or head-of-queue)
//   empty         out  1           count == 0
//   almost_empty  out  1           count <= AE_THRESH
//   underflow     out  1           sticky: a read was rejected
//   count         out  CNT_W       current occupancy
//   watermark     out  CNT_W       peak occupancy since last reset/flush
// -----------------------------------------------------------------------------
module sync_fifo_adv
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         full,
  output logic                         almost_full,
  output logic                         overflow,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         empty,
  output logic                         almost_empty,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   watermark
);

  localparam int         CNT_W = count_width(DEPTH);
  localparam int         PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // ---------------------------------------------------------------------------
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_adv: DEPTH must be >= 2 (got %0d)", DEPTH);
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_adv: DATA_WIDTH must be >= 1 (got %0d)", DATA_WIDTH);
  end
  if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_adv: need 0 < AE_THRESH(%0d) < AF_THRESH(%0d) <= DEPTH(%0d)",
           AE_THRESH, AF_THRESH, DEPTH);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nxt;
  logic [CNT_W-1:0]      watermark_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic                  wr_acc;
  logic                  rd_acc;

  // ---------------------------------------------------------------------------
  // Status decodes straight off the count register
  // ---------------------------------------------------------------------------
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;
  assign watermark    = watermark_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // ---------------------------------------------------------------------------
  // Acceptance. Flush masks both requests. A write into a full FIFO is allowed
  // only when a read frees an entry in the same cycle; a read of an empty FIFO
  // is never allowed, even alongside a write.
  // ---------------------------------------------------------------------------
  assign rd_acc = rd_en && !empty && !flush;
  assign wr_acc = wr_en && !flush && (!full || rd_acc);

  always_comb begin
    count_nxt = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  fifo_ptr_wrap #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_wrap (
    .ptr     (wr_ptr),
    .adv     (wr_acc),
    .ptr_nxt (wr_ptr_nxt)
  );

  fifo_ptr_wrap #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_wrap (
    .ptr     (rd_ptr),
    .adv     (rd_acc),
    .ptr_nxt (rd_ptr_nxt)
  );

  // ---------------------------------------------------------------------------
  // Storage: never reset, untouched by flush
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      watermark_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      watermark_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      if (count_nxt > watermark_q) begin
        watermark_q <= count_nxt;
      end
      if (wr_en && !wr_acc) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  if (MODE == FIFO_STD) begin : g_std_read
    logic [DATA_WIDTH-1:0] rd_data_p1;

    // Stage p0 -> p1: head word captured on an accepted read, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_p1 <= '0;
      end else if (rd_acc) begin
        rd_data_p1 <= mem[rd_ptr];
      end
    end

    assign rd_data = rd_data_p1;
  end else begin : g_fwft_read
    // Head word presented combinationally; meaningless while empty.
    assign rd_data = mem[rd_ptr];
  end

endmodule

// File: tb/tb_sync_fifo_adv.sv
module tb_sync_fifo_adv;

  localparam int DA = 16;  // instance A: registered read
  localparam int DB = 5;   // instance B: first-word-fall-through, non-power-of-two

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       fl_a, we_a, re_a;
  logic [7:0] wd_a, rdd_a;
  logic       full_a, af_a, ovf_a, emp_a, ae_a, unf_a;
  logic [4:0] cnt_a, wm_a;

  logic       fl_b, we_b, re_b;
  logic [7:0] wd_b, rdd_b;
  logic       full_b, af_b, ovf_b, emp_b, ae_b, unf_b;
  logic [2:0] cnt_b, wm_b;

  sync_fifo_adv #(.DATA_WIDTH(8), .DEPTH(DA), .FWFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(fl_a), .wr_en(we_a), .wr_data(wd_a),
    .full(full_a), .almost_full(af_a), .overflow(ovf_a), .rd_en(re_a),
    .rd_data(rdd_a), .empty(emp_a), .almost_empty(ae_a), .underflow(unf_a),
    .count(cnt_a), .watermark(wm_a)
  );

  sync_fifo_adv #(.DATA_WIDTH(8), .DEPTH(DB), .FWFT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(fl_b), .wr_en(we_b), .wr_data(wd_b),
    .full(full_b), .almost_full(af_b), .overflow(ovf_b), .rd_en(re_b),
    .rd_data(rdd_b), .empty(emp_b), .almost_empty(ae_b), .underflow(unf_b),
    .count(cnt_b), .watermark(wm_b)
  );

  // Reference model: a queue per FIFO plus the sticky flags and peak size.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         movf_a, munf_a, movf_b, munf_b;
  int         mwm_a, mwm_b;
  logic [7:0] mrd_a;

  int    tests = 0;
  int    fails = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    movf_a = 0; munf_a = 0; movf_b = 0; munf_b = 0;
    mwm_a = 0; mwm_b = 0; mrd_a = 8'h00;
  endtask

  task automatic model_a();
    int sz;
    bit rok, wok;
    if (!rst_n) begin
      qa.delete(); movf_a = 0; munf_a = 0; mwm_a = 0; mrd_a = 8'h00;
    end else if (fl_a) begin
      qa.delete(); movf_a = 0; munf_a = 0; mwm_a = 0;
    end else begin
      sz  = qa.size();
      rok = re_a && sz > 0;
      wok = we_a && (sz < DA || rok);
      if (rok) mrd_a = qa.pop_front();
      if (wok) qa.push_back(wd_a);
      if (we_a && !wok) movf_a = 1;
      if (re_a && sz == 0) munf_a = 1;
      if (qa.size() > mwm_a) mwm_a = qa.size();
    end
  endtask

  task automatic model_b();
    int sz;
    bit rok, wok;
    logic [7:0] dummy;
    if (!rst_n) begin
      qb.delete(); movf_b = 0; munf_b = 0; mwm_b = 0;
    end else if (fl_b) begin
      qb.delete(); movf_b = 0; munf_b = 0; mwm_b = 0;
    end else begin
      sz  = qb.size();
      rok = re_b && sz > 0;
      wok = we_b && (sz < DB || rok);
      if (rok) dummy = qb.pop_front();
      if (wok) qb.push_back(wd_b);
      if (we_b && !wok) movf_b = 1;
      if (re_b && sz == 0) munf_b = 1;
      if (qb.size() > mwm_b) mwm_b = qb.size();
    end
  endtask

  task automatic check_a();
    check("A.count", cnt_a, qa.size());
    check("A.full", full_a, qa.size() == DA);
    check("A.empty", emp_a, qa.size() == 0);
    check("A.almost_full", af_a, qa.size() >= DA - 2);
    check("A.almost_empty", ae_a, qa.size() <= 2);
    check("A.overflow", ovf_a, movf_a);
    check("A.underflow", unf_a, munf_a);
    check("A.watermark", wm_a, mwm_a);
    check("A.rd_data", rdd_a, mrd_a);
  endtask

  task automatic check_b();
    check("B.count", cnt_b, qb.size());
    check("B.full", full_b, qb.size() == DB);
    check("B.empty", emp_b, qb.size() == 0);
    check("B.almost_full", af_b, qb.size() >= DB - 2);
    check("B.almost_empty", ae_b, qb.size() <= 2);
    check("B.overflow", ovf_b, movf_b);
    check("B.underflow", unf_b, munf_b);
    check("B.watermark", wm_b, mwm_b);
    if (qb.size() > 0) check("B.rd_data", rdd_b, qb[0]);
  endtask

  // One clock: model follows the pre-edge inputs, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_a();
    model_b();
    #1;
    check_a();
    check_b();
  endtask

  task automatic idle();
    fl_a = 0; we_a = 0; re_a = 0; wd_a = 8'h00;
    fl_b = 0; we_b = 0; re_b = 0; wd_b = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();

    phase = "reset";
    tick();
    tick();
    check("A.reset_empty", emp_a, 1'b1);
    check("A.reset_full", full_a, 1'b0);
    rst_n = 1'b1;
    tick();

    // Fill A with 0x01..0x10; almost_full must appear exactly at count 14.
    phase = "fill";
    for (int i = 1; i <= DA; i++) begin
      we_a = 1; wd_a = 8'(i);
      tick();
      if (i == 13) check("A.af_at13", af_a, 1'b0);
      if (i == 14) check("A.af_at14", af_a, 1'b1);
    end
    check("A.full_after16", full_a, 1'b1);

    phase = "full_wr_rd";
    we_a = 1; re_a = 1; wd_a = 8'h11;
    tick();
    check("A.cnt_stays16", cnt_a, 16);
    check("A.no_overflow", ovf_a, 1'b0);
    check("A.first_read", rdd_a, 8'h01);

    phase = "full_wr_only";
    we_a = 1; re_a = 0; wd_a = 8'h22;
    tick();
    check("A.overflow_set", ovf_a, 1'b1);

    phase = "drain";
    we_a = 0; re_a = 1;
    for (int i = 0; i < DA; i++) tick();
    check("A.last_read", rdd_a, 8'h11);
    check("A.empty_after_drain", emp_a, 1'b1);

    phase = "empty_wr_rd";
    we_a = 1; re_a = 1; wd_a = 8'h33;
    tick();
    check("A.cnt_1", cnt_a, 1);
    check("A.underflow_set", unf_a, 1'b1);
    check("A.rd_held", rdd_a, 8'h11);
    idle();
    fl_a = 1;
    tick();
    idle();

    // B: 12 writes interleaved with reads so both pointers wrap twice.
    phase = "fwft_wrap";
    for (int i = 0; i < 12; i++) begin
      we_b = 1; wd_b = 8'hC0 + 8'(i); re_b = (i >= 4);
      tick();
    end
    we_b = 0; re_b = 1;
    for (int i = 0; i < 5; i++) tick();
    check("B.underflow_after_drain", unf_b, 1'b1);
    idle();
    fl_b = 1;
    tick();
    idle();

    // Randomised traffic: write-heavy half, then read-heavy half.
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp   = (i < 200) ? 3 : 1;
      we_a = ($urandom_range(0, 3) < wp);
      re_a = ($urandom_range(0, 3) >= wp);
      wd_a = 8'($urandom);
      fl_a = ($urandom_range(0, 59) == 0);
      we_b = ($urandom_range(0, 3) < wp);
      re_b = ($urandom_range(0, 3) >= wp);
      wd_b = 8'($urandom);
      fl_b = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle();

    phase = "watermark";
    fl_a = 1;
    tick();
    fl_a = 0; we_a = 1;
    for (int i = 0; i < 9; i++) begin
      wd_a = 8'h40 + 8'(i);
      tick();
    end
    we_a = 0; re_a = 1;
    for (int i = 0; i < 6; i++) tick();
    check("A.cnt_3", cnt_a, 3);
    check("A.wm_9", wm_a, 9);
    re_a = 0; fl_a = 1;
    tick();
    check("A.flush_cnt", cnt_a, 0);
    check("A.flush_wm", wm_a, 0);
    fl_a = 0; we_a = 1; wd_a = 8'hAB;
    tick();
    we_a = 0; re_a = 1;
    tick();
    check("A.read_AB", rdd_a, 8'hAB);
    idle();

    phase = "async_reset";
    fl_a = 1; fl_b = 1;
    tick();
    fl_a = 0; fl_b = 0; we_a = 1;
    for (int i = 0; i < 7; i++) begin
      wd_a = 8'h70 + 8'(i);
      tick();
    end
    check("A.cnt_7", cnt_a, 7);
    wd_a = 8'h77;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("A.async_cnt", cnt_a, 0);
    check("A.async_empty", emp_a, 1'b1);
    check("A.async_ae", ae_a, 1'b1);
    check("A.async_rd", rdd_a, 8'h00);
    check_a();
    check_b();
    idle();
    tick();
    rst_n = 1'b1;
    we_a = 1; wd_a = 8'h5A; we_b = 1; wd_b = 8'h5A;
    tick();
    check("B.head_5A", rdd_b, 8'h5A);
    idle();
    re_a = 1;
    tick();
    check("A.read_5A", rdd_a, 8'h5A);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
